// File: rtl/pc_gen_multi.sv
// Fetch PC generator: holds the fetch PC, arbitrates prioritised redirects, supports halt/resume.
// Optional redirect counter output redir_cnt is built when PCGEN_REDIR_CNT_EN is defined.
module pc_gen_multi #(
  parameter int                     PC_WIDTH   = 32,
  parameter logic [PC_WIDTH-1:0]    RESET_PC   = 32'h8000_0000,
  parameter int                     INST_BYTES = 4,
  parameter int                     NUM_REDIR  = 3
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REDIR-1:0]          redir_valid,
  input  logic [NUM_REDIR*PC_WIDTH-1:0] redir_pc,
  input  logic                          halt_req,
  input  logic                          resume,
  input  logic                          fetch_ready,
  output logic                          fetch_valid,
  output logic [PC_WIDTH-1:0]           fetch_pc,
  output logic [PC_WIDTH-1:0]           fetch_pc_next,
  output logic [NUM_REDIR-1:0]          redir_grant,
  output logic                          flush,
  output logic                          misalign,
  output logic [1:0]                    dbg_state
`ifdef PCGEN_REDIR_CNT_EN
  ,
  output logic [31:0]                   redir_cnt
`endif
);

  localparam logic [1:0] ST_BOOT = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_HALT = 2'd2;

  localparam logic [PC_WIDTH-1:0] OFF_MASK = PC_WIDTH'(INST_BYTES - 1);
  localparam logic [PC_WIDTH-1:0] PC_INC   = PC_WIDTH'(INST_BYTES);

  // Handshake: fetch_pc is offered while fetch_valid=1 and consumed on a cycle
  // where fetch_valid and fetch_ready are both high (a fire); it holds otherwise.
  logic [1:0]           state_q, state_d;
  logic [PC_WIDTH-1:0]  pc_q, pc_d;
  logic [NUM_REDIR-1:0] grant;
  logic [PC_WIDTH-1:0]  win_pc;
  logic                 redir_take;
  logic                 fire;

  // Scan from the highest index down so the lowest-index requester wins.
  always_comb begin
    grant  = '0;
    win_pc = '0;
    for (int i = NUM_REDIR - 1; i >= 0; i--) begin
      if (redir_valid[i]) begin
        grant  = NUM_REDIR'(1) << i;
        win_pc = redir_pc[i*PC_WIDTH +: PC_WIDTH];
      end
    end
  end

  assign redir_take    = rst_n & (|redir_valid);
  assign redir_grant   = rst_n ? grant : '0;
  assign flush         = redir_take;
  assign misalign      = redir_take & (|(win_pc & OFF_MASK));
  assign fetch_valid   = (state_q == ST_RUN);
  assign fire          = fetch_valid & fetch_ready;
  assign fetch_pc      = pc_q;
  assign fetch_pc_next = pc_q + PC_INC;
  assign dbg_state     = state_q;

  always_comb begin
    pc_d    = pc_q;
    state_d = state_q;
    if (redir_take) begin
      // A redirect always lands in RUN, squashing any fire and cancelling halt_req.
      pc_d    = win_pc & ~OFF_MASK;
      state_d = ST_RUN;
    end else begin
      if (fire) pc_d = pc_q + PC_INC;
      case (state_q)
        ST_BOOT: state_d = halt_req ? ST_HALT : ST_RUN;
        ST_RUN:  state_d = halt_req ? ST_HALT : ST_RUN;
        ST_HALT: state_d = resume   ? ST_RUN  : ST_HALT;
        default: state_d = ST_BOOT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_BOOT;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

`ifdef PCGEN_REDIR_CNT_EN
  logic [31:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (flush && (cnt_q != 32'hFFFF_FFFF)) begin
      cnt_q <= cnt_q + 32'd1;
    end
  end

  assign redir_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_pc_gen_multi.sv
// Directed plus randomized bench for pc_gen_multi against a rule-level reference model.
module tb_pc_gen_multi;
  localparam int          W      = 32;
  localparam int          NR     = 3;
  localparam int          IB     = 4;
  localparam logic [31:0] RST_PC = 32'h8000_0000;
  localparam int          M_BOOT = 0;
  localparam int          M_RUN  = 1;
  localparam int          M_HALT = 2;

  logic          clk;
  logic          rst_n;
  logic [NR-1:0] redir_valid;
  logic [NR*W-1:0] redir_pc;
  logic          halt_req;
  logic          resume;
  logic          fetch_ready;
  logic          fetch_valid;
  logic [W-1:0]  fetch_pc;
  logic [W-1:0]  fetch_pc_next;
  logic [NR-1:0] redir_grant;
  logic          flush;
  logic          misalign;
  logic [1:0]    dbg_state;
`ifdef PCGEN_REDIR_CNT_EN
  logic [31:0]   redir_cnt;
`endif

  pc_gen_multi #(
    .PC_WIDTH(W), .RESET_PC(RST_PC), .INST_BYTES(IB), .NUM_REDIR(NR)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .redir_valid(redir_valid), .redir_pc(redir_pc),
    .halt_req(halt_req), .resume(resume), .fetch_ready(fetch_ready),
    .fetch_valid(fetch_valid), .fetch_pc(fetch_pc), .fetch_pc_next(fetch_pc_next),
    .redir_grant(redir_grant), .flush(flush), .misalign(misalign),
    .dbg_state(dbg_state)
`ifdef PCGEN_REDIR_CNT_EN
    , .redir_cnt(redir_cnt)
`endif
  );

  // Clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int           n_cmp  = 0;
  int           n_fail = 0;
  int           m_mode;
  logic [W-1:0] m_pc;
  logic [31:0]  m_cnt;
  logic [W-1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive at posedge+1, check at negedge, advance the model at posedge.
  task automatic step(input logic [NR-1:0] rv, input logic [W-1:0] t0, input logic [W-1:0] t1,
                      input logic [W-1:0] t2, input logic hr, input logic rs, input logic fr);
    int            w;
    logic [W-1:0]  tgt;
    logic [NR-1:0] eg;
    logic          emis;
    redir_valid = rv;
    redir_pc    = {t2, t1, t0};
    halt_req    = hr;
    resume      = rs;
    fetch_ready = fr;
    w = -1;
    for (int i = 0; i < NR; i++) if (w < 0 && rv[i]) w = i;
    tgt  = (w == 0) ? t0 : (w == 1) ? t1 : t2;
    eg   = (w < 0) ? '0 : NR'(1) << w;
    emis = (w >= 0) && ((tgt % IB) != 0);
    @(negedge clk);
    check("grant", 32'(redir_grant), 32'(eg));
    check("flush", 32'(flush), 32'(w >= 0));
    check("misalign", 32'(misalign), 32'(emis));
    check("fetch_valid", 32'(fetch_valid), 32'(m_mode == M_RUN));
    check("fetch_pc", fetch_pc, m_pc);
    check("fetch_pc_next", fetch_pc_next, m_pc + 32'(IB));
`ifdef PCGEN_REDIR_CNT_EN
    check("redir_cnt", redir_cnt, m_cnt);
`endif
    if (m_mode == M_RUN && fr) exp_q.push_back(m_pc);
    if (fetch_valid && fetch_ready) begin
      if (exp_q.size() == 0) check("unexpected_fire", 32'd1, 32'd0);
      else check("fired_pc", fetch_pc, exp_q.pop_front());
    end
    @(posedge clk);
    if (w >= 0) begin
      m_pc   = tgt - (tgt % IB);
      m_mode = M_RUN;
      if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
    end else begin
      if (m_mode == M_RUN && fr) m_pc = m_pc + 32'(IB);
      if (m_mode == M_HALT) m_mode = rs ? M_RUN : M_HALT;
      else m_mode = hr ? M_HALT : M_RUN;
    end
    #1;
  endtask

  task automatic idle(input logic hr, input logic rs, input logic fr);
    step('0, '0, '0, '0, hr, rs, fr);
  endtask

  task automatic redir1(input int ch, input logic [W-1:0] tgt, input logic hr, input logic fr);
    logic [NR-1:0] rv;
    rv = NR'(1) << ch;
    step(rv, tgt, tgt, tgt, hr, 1'b0, fr);
  endtask

  // Reset asserted between edges; outputs must react without a clock.
  task automatic async_reset();
    #2;
    rst_n = 1'b0;
    redir_valid = '0; halt_req = 1'b0; resume = 1'b0; fetch_ready = 1'b0;
    #1;
    check("rst_pc", fetch_pc, RST_PC);
    check("rst_valid", 32'(fetch_valid), 32'd0);
    check("rst_flush", 32'(flush), 32'd0);
    m_mode = M_BOOT; m_pc = RST_PC; m_cnt = '0;
    exp_q.delete();
`ifdef PCGEN_REDIR_CNT_EN
    check("rst_cnt", redir_cnt, 32'd0);
`endif
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    logic [NR-1:0] rv;
    rst_n = 1'b0; redir_valid = '0; redir_pc = '0;
    halt_req = 1'b0; resume = 1'b0; fetch_ready = 1'b0;
    m_mode = M_BOOT; m_pc = RST_PC; m_cnt = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_pc", fetch_pc, RST_PC);
    check("reset_valid", 32'(fetch_valid), 32'd0);
    check("reset_grant", 32'(redir_grant), 32'd0);
    check("reset_misalign", 32'(misalign), 32'd0);
    rst_n = 1'b1;

    repeat (5) idle(1'b0, 1'b0, 1'b1);
    check("seq_pc_0010", fetch_pc, 32'h8000_0010);
    repeat (3) idle(1'b0, 1'b0, 1'b0);
    check("stall_hold", fetch_pc, 32'h8000_0010);
    idle(1'b0, 1'b0, 1'b1);
    check("stall_release", fetch_pc, 32'h8000_0014);

    step(3'b110, 32'h0, 32'h8000_1000, 32'h8000_2000, 1'b0, 1'b0, 1'b1);
    check("redir_beats_fire", fetch_pc, 32'h8000_1000);

    redir1(0, 32'h8000_0020, 1'b0, 1'b0);
    idle(1'b1, 1'b0, 1'b1);
    check("halt_pc", fetch_pc, 32'h8000_0024);
    check("halt_valid", 32'(fetch_valid), 32'd0);
    idle(1'b1, 1'b0, 1'b1);
    idle(1'b1, 1'b1, 1'b0);
    check("resume_valid", 32'(fetch_valid), 32'd1);
    idle(1'b1, 1'b0, 1'b0);
    check("halt2_valid", 32'(fetch_valid), 32'd0);
    redir1(0, 32'h8000_0102, 1'b0, 1'b0);
    check("misalign_pc", fetch_pc, 32'h8000_0100);
    check("misalign_run", 32'(fetch_valid), 32'd1);

    redir1(1, 32'hFFFF_FFFC, 1'b0, 1'b1);
    check("wrap_start", fetch_pc, 32'hFFFF_FFFC);
    idle(1'b0, 1'b0, 1'b1);
    check("wrap_zero", fetch_pc, 32'h0000_0000);
    idle(1'b0, 1'b0, 1'b1);
    check("wrap_four", fetch_pc, 32'h0000_0004);

    redir1(2, 32'h8000_0200, 1'b1, 1'b1);
    check("halt_dropped_by_redir", 32'(fetch_valid), 32'd1);
    idle(1'b0, 1'b0, 1'b1);

    async_reset();
    idle(1'b1, 1'b0, 1'b1);
    idle(1'b0, 1'b0, 1'b1);
    check("boot_to_halt", 32'(fetch_valid), 32'd0);
    async_reset();
    idle(1'b0, 1'b0, 1'b1);

    for (int k = 0; k < 5; k++) redir1(k % NR, 32'h8000_4000 + 32'(k * 16), 1'b0, 1'b1);
    idle(1'b0, 1'b0, 1'b0);
`ifdef PCGEN_REDIR_CNT_EN
    check("cnt_five", redir_cnt, 32'd5);
    async_reset();
    check("cnt_cleared", redir_cnt, 32'd0);
`endif

    for (int c = 0; c < 600; c++) begin
      rv = ($urandom_range(0, 3) == 0) ? NR'($urandom_range(1, 7)) : '0;
      if ($urandom_range(0, 150) == 0) async_reset();
      else step(rv, $urandom, $urandom_range(0, 7) == 0 ? 32'hFFFF_FFFC : $urandom, $urandom,
                $urandom_range(0, 5) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 2) != 0);
    end

    check("exp_q_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/pc_gen_multi.md
Name: pc_gen_multi

Overview:
- Parametrised next-generation fetch PC generator for the NPC front end.
- Holds the architectural fetch PC and presents it to fetch over a valid/ready handshake.
- Arbitrates NUM_REDIR prioritised redirect sources (e.g. trap, branch, jump) and supports halt/resume.
- Sits between the execute/commit redirect logic and the instruction-fetch unit.

Parameters:
- PC_WIDTH, 32, width of all PC values
- RESET_PC, 32'h8000_0000, PC loaded on reset (PC_WIDTH bits)
- INST_BYTES, 4, sequential increment; power of two, 2 or 4
- NUM_REDIR, 3, number of redirect channels; channel 0 has highest priority

Ports:
- clk, input, 1, clock; all state updates on the rising edge
- rst_n, input, 1, asynchronous active-low reset
- redir_valid, input, NUM_REDIR, per-channel redirect request
- redir_pc, input, NUM_REDIR*PC_WIDTH, per-channel target; channel i occupies bits [i*PC_WIDTH +: PC_WIDTH]
- halt_req, input, 1, request to stop issuing fetches
- resume, input, 1, leave HALT
- fetch_ready, input, 1, fetch accepts fetch_pc this cycle
- fetch_valid, output, 1, fetch_pc is valid
- fetch_pc, output, PC_WIDTH, current PC (register)
- fetch_pc_next, output, PC_WIDTH, fetch_pc + INST_BYTES (combinational)
- redir_grant, output, NUM_REDIR, one-hot winning channel this cycle (combinational)
- flush, output, 1, redirect taken this cycle; the in-flight fetch is squashed
- misalign, output, 1, winning target has nonzero bits [log2(INST_BYTES)-1:0]

Behaviour:
- Reset (rst_n low, asynchronous): state=BOOT, fetch_pc=RESET_PC, fetch_valid=0, redir_grant=0, flush=0, misalign=0. Reset mid-operation discards any pending redirect or halt.
- States:
  - BOOT: fetch_valid=0 for exactly one cycle after reset release.
  - RUN: fetch_valid=1.
  - HALT: fetch_valid=0.
- Fire = fetch_valid & fetch_ready.
- Redirect arbitration:
  - Winner is the lowest-index channel with redir_valid=1. redir_grant is one-hot on the winner, or all zero if none.
  - flush = |redir_valid, in every state.
- Next-PC priority, highest first:
  1. Redirect: fetch_pc <= winner target with bits [log2(INST_BYTES)-1:0] forced to 0. misalign = 1 in that cycle if the forced bits were nonzero.
  2. Fire in RUN: fetch_pc <= fetch_pc + INST_BYTES.
  3. Otherwise: hold.
- Redirect and fire in the same cycle: redirect wins. The fired PC is squashed by flush; no increment is applied.
- Increment wraps modulo 2^PC_WIDTH, e.g. FFFF_FFFC -> 0000_0000 for INST_BYTES=4.
- State transitions:
  - BOOT -> HALT if halt_req, else BOOT -> RUN. A redirect in BOOT still loads the PC.
  - RUN -> HALT when halt_req=1 and no redirect. A fire in that same cycle still advances the PC.
  - RUN with halt_req=1 and a redirect: the redirect loads the PC and the state stays RUN. halt_req must be re-asserted.
  - HALT -> RUN on resume or on any redirect (the redirect loads the PC). halt_req has no effect in HALT. If resume and halt_req are both high, resume wins.
- fetch_pc changes only on a redirect or a fire; it is stable while fetch_valid=1 and fetch_ready=0.
- Latency: a redirect asserted in cycle N appears on fetch_pc in cycle N+1, with fetch_valid=1 in N+1 (state RUN).

Optional Feature:
- Macro PCGEN_REDIR_CNT_EN.
- When defined: adds output redir_cnt [31:0], reset to 0, incremented by 1 on every cycle with flush=1, saturating at FFFF_FFFF.
- When undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset release, fetch_ready=1 constant -> cycle 0 fetch_valid=0 with fetch_pc=8000_0000; then fetch_pc sequence 8000_0000, 8000_0004, 8000_0008.
- fetch_ready=0 for 3 cycles at PC 8000_0010 -> fetch_pc holds 8000_0010 with fetch_valid=1; advances to 8000_0014 one cycle after fetch_ready returns to 1.
- Same cycle: redir_valid=3'b110, ch1 target 8000_1000, ch2 target 8000_2000, fire=1 -> redir_grant=3'b010, flush=1, next fetch_pc=8000_1000.
- halt_req pulse at PC 8000_0020 with fire -> next PC 8000_0024 in HALT, fetch_valid=0; resume -> fetch_valid=1 at 8000_0024. Second halt, then ch0 redirect to 8000_0102 -> misalign=1, state RUN, fetch_pc=8000_0100.
- Redirect to FFFF_FFFC, then 2 fires -> fetch_pc FFFF_FFFC, 0000_0000, 0000_0004.
- rst_n asserted mid-run and while in HALT -> fetch_pc=8000_0000 and fetch_valid=0 immediately, without waiting for a clock edge. With PCGEN_REDIR_CNT_EN: 5 redirects -> redir_cnt=5, cleared to 0 by reset.
